// File: rtl/barker_frame_arbiter.sv
// ============================================================================
// barker_frame_arbiter - frame-atomic round-robin arbiter onto one correlator stream.
// Optional stall timeout with forced release: define BARKER_ARB_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module barker_frame_arbiter #(
    parameter int N_SRC       = 4,
    parameter int SRC_W       = $clog2(N_SRC),
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0] s_axis_tvalid,
    input  logic [N_SRC-1:0] s_axis_tlast,
    output logic [N_SRC-1:0] s_axis_tready,
    output logic             m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic [SRC_W-1:0] m_axis_tid,
    input  logic             m_axis_tready,
    output logic             o_busy,
    output logic [15:0]      o_frame_cnt,
    output logic             o_timeout
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] grant_next;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_next;
    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] grant_inc;
    logic             pick_found;
    logic             handshake;
    logic             force_release;
    logic             busy_next;
    logic [15:0]      frame_cnt_next;

    // Modulo-N_SRC add; operands are always below N_SRC so one subtraction suffices.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_SRC) begin
            sum = sum - N_SRC;
        end
        return SRC_W'(sum);
    endfunction

    always_comb begin
        pick       = rr_ptr;
        pick_found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (!pick_found && s_axis_tvalid[wrap_add(rr_ptr, k)]) begin
                pick       = wrap_add(rr_ptr, k);
                pick_found = 1'b1;
            end
        end
    end

    assign grant_inc  = wrap_add(grant, 1);
    assign handshake  = (state == S_XFER) & s_axis_tvalid[grant] & m_axis_tready;
    assign m_axis_tid = grant;

    always_comb begin
        state_next     = state;
        grant_next     = grant;
        rr_next        = rr_ptr;
        busy_next      = o_busy;
        frame_cnt_next = o_frame_cnt;
        s_axis_tready  = '0;
        m_axis_tdata   = 1'b0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    grant_next = pick;
                    state_next = S_XFER;
                    busy_next  = 1'b1;
                end
            end
            S_XFER: begin
                m_axis_tdata         = s_axis_tdata[grant];
                m_axis_tvalid        = s_axis_tvalid[grant];
                m_axis_tlast         = s_axis_tlast[grant];
                s_axis_tready[grant] = m_axis_tready;
                if (handshake && s_axis_tlast[grant]) begin
                    state_next     = S_IDLE;
                    busy_next      = 1'b0;
                    rr_next        = grant_inc;
                    frame_cnt_next = o_frame_cnt + 16'd1;
                end else if (force_release) begin
                    // Truncated frame: released without counting it.
                    state_next = S_IDLE;
                    busy_next  = 1'b0;
                    rr_next    = grant_inc;
                end
            end
            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            o_busy      <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            rr_ptr      <= rr_next;
            o_busy      <= busy_next;
            o_frame_cnt <= frame_cnt_next;
        end
    end

`ifdef BARKER_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] stall_cnt;
    logic             timeout_q;

    assign force_release = (state == S_XFER) && !handshake &&
                           (stall_cnt == TMO_W'(TIMEOUT_CYC - 1));

    // Idle keeps the counter at zero, which covers the clear on entry to S_XFER.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_release;
            if ((state != S_XFER) || handshake) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign force_release      = 1'b0;
    assign o_timeout          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_barker_frame_arbiter.sv
// ============================================================================
// tb_barker_frame_arbiter - scoreboard bench for barker_frame_arbiter (N_SRC=4, TIMEOUT_CYC=8).
// ============================================================================
`default_nettype none

module tb_barker_frame_arbiter;

    localparam logic [10:0] BARKER11 = 11'b11100010010;
`ifdef BARKER_ARB_TIMEOUT_EN
    localparam int EXP_PULSES = 1;
`else
    localparam int EXP_PULSES = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic        m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [1:0]  m_tid;
    logic        m_tready;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        timeout;

    barker_frame_arbiter #(.N_SRC(4), .TIMEOUT_CYC(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tready (m_tready),
        .o_busy        (busy),
        .o_frame_cnt   (frame_cnt),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] mask;
        logic [3:0] data;
        logic [1:0] tid;
        logic       d;
    } vec_t;

    vec_t       vecs [10];
    logic [1:0] src_q [4][$];
    logic [3:0] sb [$];
    logic [3:0] hold = '0;
    logic [3:0] hs_src = '0;
    logic       tog_mode = 1'b0;
    logic       gap_chk = 1'b0;
    logic       prev_was_last = 1'b1;
    int         last_tlast_cyc = -1;
    int         cycle = 0;
    int         checks = 0;
    int         errors = 0;
    int         exp_frames = 0;
    int         to_pulses = 0;
    int         stall_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i]  = src_q[i][0][1];
                s_tlast[i]  = src_q[i][0][0];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i]  = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic [3:0] exp;
        hs_src = s_tvalid & s_tready;
        if (rst_n) begin
            chk("tready_onehot", 32'($countones(s_tready) <= 1), 32'd1);
            if (timeout) to_pulses++;
            if (busy && !m_tvalid) stall_cycles++;
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {m_tid, m_tdata, m_tlast}, 32'hF0);
                end else begin
                    exp = sb.pop_front();
                    chk("beat", {m_tid, m_tdata, m_tlast}, exp);
                end
                if (gap_chk && prev_was_last && last_tlast_cyc >= 0)
                    chk("frame_gap", cycle - last_tlast_cyc, 2);
                prev_was_last = m_tlast;
                if (m_tlast) last_tlast_cyc = cycle;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < 4; i++)
            if (hs_src[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        hs_src = '0;
        if (tog_mode) m_tready = ~m_tready;
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) src_q[i].delete();
        hs_src = '0;
        hold   = '0;
    endtask

    task automatic enq_frame(input int src, input int n_exp);
        logic [10:0] pat;
        logic [1:0]  b;
        pat = BARKER11;
        for (int k = 0; k < 11; k++) begin
            b = {pat[10-k], k == 10};
            src_q[src].push_back(b);
            if (k < n_exp) begin
                sb.push_back({2'(src), b});
                if (k == 10) exp_frames++;
            end
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (sb.size() > 0 && n < max) begin
            cyc();
            n++;
        end
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int k = 0; k < n; k++) begin
            cyc();
            chk("reset_outputs", {s_tready, m_tvalid, m_tlast, m_tdata, m_tid, busy, timeout, frame_cnt}, 32'd0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        m_tready = 1'b1;
        // Reset with every source presenting data, then 0,1,2,3,0 rotation.
        enq_frame(0, 11); enq_frame(1, 11); enq_frame(2, 11); enq_frame(3, 11);
        enq_frame(0, 11); enq_frame(1, 0);  enq_frame(2, 0);  enq_frame(3, 0);
        drive();
        do_reset(3);
        gap_chk = 1'b1;
        cyc();
        chk("first_grant", {m_tvalid, m_tid}, {1'b1, 2'd0});
        wait_drain("rotation_done", 400);
        flush();
        cyc();
        chk("frame_cnt_rotation", frame_cnt, 5);

        // Single source, back-to-back frames.
        last_tlast_cyc = -1;
        prev_was_last  = 1'b1;
        enq_frame(2, 11); enq_frame(2, 11); enq_frame(2, 11);
        wait_drain("same_src_done", 200);
        flush();
        gap_chk = 1'b0;
        cyc();
        chk("frame_cnt_same_src", frame_cnt, exp_frames[15:0]);

        // Backpressure on source 1 while source 0 waits.
        enq_frame(0, 11);
        wait_drain("src0_done", 100);
        flush();
        enq_frame(1, 11);
        enq_frame(0, 0);
        tog_mode = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            cyc();
            n++;
            if (m_tvalid) chk("tready_mirror", s_tready, {2'b00, m_tready, 1'b0});
        end
        chk("toggle_done", sb.size(), 0);
        chk("src0_untouched", src_q[0].size(), 11);
        flush();
        tog_mode = 1'b0;
        m_tready = 1'b1;
        cyc();
        chk("frame_cnt_toggle", frame_cnt, exp_frames[15:0]);

`ifdef BARKER_ARB_TIMEOUT_EN
        // Source 0 stalls after four beats; forced release hands over to source 1.
        enq_frame(0, 4);
        enq_frame(1, 11);
        n = 0;
        while ((11 - src_q[0].size() + int'(hs_src[0])) < 4 && n < 50) begin
            cyc();
            n++;
        end
        hold[0]      = 1'b1;
        stall_cycles = 0;
        to_pulses    = 0;
        wait_drain("timeout_done", 200);
        chk("stall_cycles", stall_cycles, 8);
        flush();
        cyc();
        chk("frame_cnt_timeout", frame_cnt, exp_frames[15:0]);
`else
        // Source 3 pauses mid-frame while the others request.
        enq_frame(3, 11);
        n = 0;
        while ((11 - src_q[3].size() + int'(hs_src[3])) < 5 && n < 50) begin
            cyc();
            n++;
        end
        hold[3] = 1'b1;
        enq_frame(0, 0); enq_frame(1, 0); enq_frame(2, 0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("pause_hold", {busy, m_tvalid, m_tid}, {1'b1, 1'b0, 2'd3});
        end
        hold[3] = 1'b0;
        wait_drain("pause_done", 100);
        flush();
        cyc();
        chk("frame_cnt_pause", frame_cnt, exp_frames[15:0]);
`endif

        // Arbitration table from a fresh pointer: single-beat frames.
        vecs[0] = '{4'b1111, 4'b1010, 2'd0, 1'b0};
        vecs[1] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[2] = '{4'b1001, 4'b0110, 2'd3, 1'b0};
        vecs[3] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
        vecs[4] = '{4'b0110, 4'b1011, 2'd2, 1'b0};
        vecs[5] = '{4'b0011, 4'b1101, 2'd0, 1'b1};
        vecs[6] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[7] = '{4'b1100, 4'b0100, 2'd2, 1'b1};
        vecs[8] = '{4'b1100, 4'b0111, 2'd3, 1'b0};
        vecs[9] = '{4'b0101, 4'b1110, 2'd0, 1'b0};
        flush();
        sb.delete();
        do_reset(2);
        exp_frames = 0;
        for (int r = 0; r < 10; r++) begin
            flush();
            for (int i = 0; i < 4; i++)
                if (vecs[r].mask[i]) src_q[i].push_back({vecs[r].data[i], 1'b1});
            sb.push_back({vecs[r].tid, vecs[r].d, 1'b1});
            exp_frames++;
            wait_drain("table_done", 20);
        end
        flush();
        cyc();
        chk("frame_cnt_table", frame_cnt, exp_frames[15:0]);
        chk("timeout_pulses", to_pulses, EXP_PULSES);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/barker_frame_arbiter.md
Name: barker_frame_arbiter

Overview:
- Frame-atomic round-robin arbiter that shares one barker correlator input stream between N_SRC independent 1-bit AXI-Stream sequence sources (test generators or channel front-ends).
- Grants one source per frame and holds the grant until that source's tlast beat completes.
- Tags every output beat with the source index so downstream correlation results can be attributed.
- Sits between the source bank and the correlator s_axis port.

Parameters:
- N_SRC, 4, number of requesting sources (2..16).
- SRC_W, $clog2(N_SRC), width of the source index.
- TIMEOUT_CYC, 64, stall cycles before forced release (used only with the optional feature).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  synchronous active-low reset.
- s_axis_tdata  input  N_SRC  per-source data bit.
- s_axis_tvalid  input  N_SRC  per-source valid.
- s_axis_tlast  input  N_SRC  per-source end of frame.
- s_axis_tready  output  N_SRC  per-source ready.
- m_axis_tdata  output  1  data to correlator.
- m_axis_tvalid  output  1  valid to correlator.
- m_axis_tlast  output  1  end of frame to correlator.
- m_axis_tid  output  SRC_W  index of the granted source.
- m_axis_tready  input  1  correlator ready.
- o_busy  output  1  high while a grant is held.
- o_frame_cnt  output  16  count of completed frames; wraps 0xFFFF -> 0.
- o_timeout  output  1  one-cycle pulse on forced release (always 0 without the option).

Behaviour:
- Reset: i_rst_n is synchronous and active-low on i_clk.
  - state = S_IDLE, grant = 0, rr_ptr = 0, o_frame_cnt = 0, o_busy = 0, o_timeout = 0.
  - All s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tid = 0.
- State machine:
  - S_IDLE: all s_axis_tready = 0, m_axis_tvalid = 0.
    - If any s_axis_tvalid is set, register grant = first i with tvalid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_SRC.
    - On that same edge: go to S_XFER, o_busy <= 1.
    - If no tvalid is set, stay in S_IDLE.
  - S_XFER: combinational pass-through of the granted source only.
    - m_axis_tdata/tvalid/tlast = s_axis_*[grant].
    - s_axis_tready[grant] = m_axis_tready; all other s_axis_tready = 0.
    - m_axis_tid = grant; it holds its value in S_IDLE.
    - Handshake = m_axis_tvalid & m_axis_tready.
    - Handshake with tlast:
      - state <= S_IDLE, o_busy <= 0.
      - rr_ptr <= (grant+1) mod N_SRC.
      - o_frame_cnt <= o_frame_cnt+1.
- Latency:
  - Zero-cycle data path while granted.
  - Exactly one bubble cycle (S_IDLE) between consecutive frames, including back-to-back frames from the same source.
- Boundary conditions:
  - Only the granted source can advance. tvalid from other sources never affects the output, and their beats are never consumed.
  - Granted tvalid dropping mid-frame (source pause): stay in S_XFER; the grant is held indefinitely unless the optional feature is compiled in.
  - Single-beat frame (tlast on first beat): legal; the frame is counted.
  - N_SRC not a power of two: pointer wraps at N_SRC-1 -> 0; indices >= N_SRC are never granted.
  - Reset mid-frame: the frame is abandoned with no tlast emitted; the source is responsible for its own resynchronisation.
  - m_axis_tready low: the granted s_axis_tready is low in the same cycle and no beat is lost.

Optional Feature:
- Macro: BARKER_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in S_XFER.
  - It clears on every handshake and on entry to S_XFER; it increments on every non-handshake cycle.
  - Reaching TIMEOUT_CYC-1 without a handshake forces release:
    - state <= S_IDLE, rr_ptr <= grant+1.
    - o_timeout pulses high for one cycle.
    - o_frame_cnt is not incremented and no tlast is emitted (truncated frame).
- When undefined: no counter is present, o_timeout is tied to 0, and the grant is held until tlast.

Test Plan:
- Reset held for 3 cycles with all s_axis_tvalid = 4'b1111 -> every output at its reset value and s_axis_tready = 0; first grant is to source 0, with m_axis_tid = 0 on the cycle after reset release plus 1.
- All 4 sources continuously send 11-beat frames of 11100010010 -> grant order 0,1,2,3,0; exactly 1 idle cycle between frames; o_frame_cnt = 5 after 5 frames.
- Only source 2 valid, 3 frames back-to-back -> three grants to source 2, each separated by one idle cycle; m_axis_tid = 2 throughout.
- m_axis_tready toggled 1,0,1,0 during a frame from source 1 -> s_axis_tready[1] mirrors it; 11 beats delivered in order; no beat from source 0 consumed while source 0 is valid.
- Source 3 drops tvalid for 20 cycles mid-frame -> grant held, no other source is served, frame then completes; o_frame_cnt increments by 1.
- With BARKER_ARB_TIMEOUT_EN and TIMEOUT_CYC = 8, source 0 stalls after beat 4 -> forced release after 8 stall cycles; o_timeout is one pulse; o_frame_cnt unchanged; next grant goes to source 1.
